multdiv_iter_unit: RTL and testbench

//  Parametrised iterative signed multiply/divide unit for the 5-stage pipeline's execute stage.

---
 rtl/multdiv_iter_unit.sv | 153 +++++++++++++++
 tb/tb_multdiv_iter_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter_unit.sv
// Iterative signed multiply/divide unit: one radix-2 step per clock, WIDTH steps per op.
// Valid/ready on both request and result sides; flush aborts an in-flight op.
module multdiv_iter_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_mult,
  input  logic             op_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_mult;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [TAG_W-1:0]   tag_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   shifted_rem;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

  assign in_ready = (state == IDLE) && !reset;

  assign abs_a = operandA[WIDTH-1] ? (~operandA + 1'b1) : operandA;
  assign abs_b = operandB[WIDTH-1] ? (~operandB + 1'b1) : operandB;

  // Mult keeps {product_hi, multiplier} in acc; div keeps {remainder, dividend/quotient}.
  // The remainder is always below a divisor of at most 2^(WIDTH-1), so its top bit is zero
  // and the shifted trial remainder fits in WIDTH bits.
  always_comb begin
    add_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    shifted_rem = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    hi_next     = acc_hi;
    lo_next     = acc_lo;
    if (is_mult) begin
      hi_next = add_sum[WIDTH:1];
      lo_next = {add_sum[0], acc_lo[WIDTH-1:1]};
    end else if (shifted_rem >= mag_b) begin
      hi_next = shifted_rem - mag_b;
      lo_next = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = shifted_rem;
      lo_next = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  // A positive quotient with the top bit set only arises from MIN / -1.
  always_comb begin
    prod_signed = neg ? (~{hi_next, lo_next} + 1'b1) : {hi_next, lo_next};
    quo_signed  = neg ? (~lo_next + 1'b1) : lo_next;
    if (is_mult) begin
      fin_result = prod_signed[WIDTH-1:0];
      fin_exc    = prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};
    end else begin
      fin_result = quo_signed;
      fin_exc    = !neg && lo_next[WIDTH-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      tag_out   <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && (op_mult || op_div)) begin
            is_mult <= op_mult;
            neg     <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            tag_q   <= tag_in;
            cnt     <= '0;
            busy    <= 1'b1;
            acc_hi  <= '0;
            acc_lo  <= op_mult ? abs_b : abs_a;
            if (!op_mult && (operandB == '0)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= '0;
              exception <= 1'b1;
              tag_out   <= tag_in;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc_hi <= hi_next;
          acc_lo <= lo_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= fin_result;
            exception <= fin_exc;
            tag_out   <= tag_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter_unit.sv
// Directed bench for multdiv_iter_unit: hand-computed products/quotients, latency,
// flush, result hold under back-pressure and mid-operation reset.
module tb_multdiv_iter_unit;

  localparam int W = 32;
  localparam int T = 5;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         op_mult;
  logic         op_div;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic [T-1:0] tag_in;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         exception;
  logic [T-1:0] tag_out;
  logic         busy;

  int total = 0;
  int bad   = 0;

  multdiv_iter_unit #(.WIDTH(W), .TAG_W(T)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_mult(op_mult), .op_div(op_div), .operandA(operandA), .operandB(operandB),
    .tag_in(tag_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exception(exception), .tag_out(tag_out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called one step after a rising edge with the unit idle; returns just after the accept edge
  // with the operand inputs scrambled so late sampling would be visible.
  task automatic applyStimulus(input logic m, input logic d, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [T-1:0] t);
    in_valid = 1'b1;
    op_mult  = m;
    op_div   = d;
    operandA = a;
    operandB = b;
    tag_in   = t;
    @(posedge clock); #1;
    in_valid = 1'b0;
    op_mult  = 1'b0;
    op_div   = 1'b0;
    operandA = 32'hDEADBEEF;
    operandB = 32'h12345678;
    tag_in   = 5'h1F;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic m, input logic d,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [T-1:0] t,
                       input int exp_lat, input logic [W-1:0] exp_res, input logic exp_exc);
    int lat;
    out_ready = 1'b1;
    applyStimulus(m, d, a, b, t);
    checkOutput({name, ".busy"}, 64'(busy), 64'(1'b1));
    waitResult(lat);
    checkOutput({name, ".lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, ".valid"}, 64'(out_valid), 64'(1'b1));
    checkOutput({name, ".result"}, 64'(result), 64'(exp_res));
    checkOutput({name, ".exc"}, 64'(exception), 64'(exp_exc));
    checkOutput({name, ".tag"}, 64'(tag_out), 64'(t));
    checkOutput({name, ".in_ready"}, 64'(in_ready), 64'(1'b0));
    @(posedge clock); #1;
    checkOutput({name, ".drain"}, 64'(out_valid), 64'(1'b0));
    checkOutput({name, ".idle"}, 64'(busy), 64'(1'b0));
  endtask

  initial begin
    int lat;
    int stray;
    reset = 1'b1; in_valid = 1'b0; op_mult = 1'b0; op_div = 1'b0;
    operandA = '0; operandB = '0; tag_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst.in_ready", 64'(in_ready), 64'(1'b0));
    checkOutput("rst.out_valid", 64'(out_valid), 64'(1'b0));
    checkOutput("rst.result", 64'(result), 64'(32'h0));
    checkOutput("rst.exc", 64'(exception), 64'(1'b0));
    checkOutput("rst.tag", 64'(tag_out), 64'(5'h0));
    checkOutput("rst.busy", 64'(busy), 64'(1'b0));
    reset = 1'b0;
    #1;
    checkOutput("rel.in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clock); #1;

    runOp("mul7x-6",   1, 0, 32'd7,        32'hFFFFFFFA, 5'd3,  32, 32'hFFFFFFD6, 1'b0);
    runOp("div-7/2",   0, 1, 32'hFFFFFFF9, 32'd2,        5'd4,  32, 32'hFFFFFFFD, 1'b0);
    runOp("divmin/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 5'd5,  32, 32'h80000000, 1'b1);
    runOp("div5/0",    0, 1, 32'd5,        32'd0,        5'd6,   0, 32'h00000000, 1'b1);
    runOp("mulovf",    1, 0, 32'h00010000, 32'h00010000, 5'd7,  32, 32'h00000000, 1'b1);
    runOp("mulmax",    1, 0, 32'h7FFFFFFF, 32'd1,        5'd8,  32, 32'h7FFFFFFF, 1'b0);
    runOp("div100/-7", 0, 1, 32'd100,      32'hFFFFFFF9, 5'd10, 32, 32'hFFFFFFF2, 1'b0);
    runOp("mulminx-1", 1, 0, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32, 32'h80000000, 1'b1);
    runOp("divmin/1",  0, 1, 32'h80000000, 32'd1,        5'd12, 32, 32'h80000000, 1'b0);
    runOp("mulboth",   1, 1, 32'd6,        32'd7,        5'd13, 32, 32'd42,       1'b0);
    runOp("mul-1x-1",  1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32, 32'd1,        1'b0);

    // Request without an op bit, and a request alongside flush, must both be ignored.
    in_valid = 1'b1;
    @(posedge clock); #1;
    checkOutput("noop.busy", 64'(busy), 64'(1'b0));
    op_mult = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    checkOutput("flushacc.busy", 64'(busy), 64'(1'b0));
    in_valid = 1'b0; op_mult = 1'b0; flush = 1'b0;

    applyStimulus(1, 0, 32'd100, 32'd3, 5'd2);
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1; in_valid = 1'b1; op_div = 1'b1; operandA = 32'd9; operandB = 32'd3;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0; op_div = 1'b0;
    checkOutput("flush.busy", 64'(busy), 64'(1'b0));
    checkOutput("flush.valid", 64'(out_valid), 64'(1'b0));
    checkOutput("flush.in_ready", 64'(in_ready), 64'(1'b1));
    runOp("postflush", 0, 1, 32'hFFFFFF9C, 32'd7, 5'd4, 32, 32'hFFFFFFF2, 1'b0);

    out_ready = 1'b0;
    applyStimulus(1, 0, 32'd12, 32'd11, 5'd9);
    waitResult(lat);
    checkOutput("hold.lat", 64'(lat), 64'(32));
    repeat (5) begin
      @(posedge clock); #1;
      checkOutput("hold.valid", 64'(out_valid), 64'(1'b1));
      checkOutput("hold.result", 64'(result), 64'(32'd132));
      checkOutput("hold.tag", 64'(tag_out), 64'(5'd9));
      checkOutput("hold.in_ready", 64'(in_ready), 64'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput("release.valid", 64'(out_valid), 64'(1'b0));
    checkOutput("release.in_ready", 64'(in_ready), 64'(1'b1));

    applyStimulus(1, 0, 32'hFFFFFFFB, 32'd9, 5'd7);
    repeat (5) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("midrst.valid", 64'(out_valid), 64'(1'b0));
    checkOutput("midrst.result", 64'(result), 64'(32'h0));
    checkOutput("midrst.exc", 64'(exception), 64'(1'b0));
    checkOutput("midrst.tag", 64'(tag_out), 64'(5'h0));
    checkOutput("midrst.busy", 64'(busy), 64'(1'b0));
    checkOutput("midrst.in_ready", 64'(in_ready), 64'(1'b0));
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (out_valid) stray++;
    end
    checkOutput("midrst.stray", 64'(stray), 64'(0));
    runOp("mul-5x9", 1, 0, 32'hFFFFFFFB, 32'd9, 5'd1, 32, 32'hFFFFFFD3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
